// File: rtl/mem_cmd_writer_pkg.sv
// mem_cmd_pkg: shared FSM state type and control-RAM address map for mem_cmd_writer
package mem_cmd_pkg;
    typedef enum logic {IDLE, WRITE} state_e;
    localparam int ADDR_ALGO = 0;
    localparam int ADDR_STARTPOS = 1;
endpackage

// File: rtl/mem_cmd_writer_btn_cond.sv
// btn_cond: button synchroniser, optional debouncer (BTN_DEBOUNCE_EN) and rising-edge pulse
module btn_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic lvl;
    logic lvl_q;
    // shift the raw level through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end
`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic deb_q;
    // follow the synchronised level only after it has differed for DEBOUNCE_CYC cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == deb_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            cnt_q <= '0;
            deb_q <= sync_q[SYNC_STAGES-1];
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign lvl = deb_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif
    // delayed copy of the conditioned level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lvl_q <= 1'b0;
        else lvl_q <= lvl;
    end
    assign rise_o = lvl & ~lvl_q;
endmodule

// File: rtl/mem_cmd_writer.sv
// mem_cmd_writer: queues button presses and writes algorithm/start-position bytes over a req/ack port (debounce via BTN_DEBOUNCE_EN)
module mem_cmd_writer
    import mem_cmd_pkg::*;
#(
    parameter int N_BTN = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn,
    input  logic [DATA_W-1:0] byte_pos,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
    localparam int IDX_W = $clog2(N_BTN);
    state_e state_q;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending_q, pending_d, launch_mask;
    logic [IDX_W-1:0] sel;
    logic launch;
    logic [DATA_W-1:0] pos_q;
    logic [ADDR_W-1:0] cmd_addr, mem_addr_q;
    logic [DATA_W-1:0] cmd_data, mem_data_q;
    logic mem_we_q, done_q, overrun_q;
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_cond #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
            .clk(clk),
            .rst(rst),
            .btn_i(btn[i]),
            .rise_o(rise[i])
        );
    end
    // pick the lowest pending request and build its command; a same-cycle rise re-arms the launched bit
    always_comb begin
        sel = '0;
        for (int i = N_BTN - 1; i >= 0; i--) sel = pending_q[i] ? IDX_W'(i) : sel;
        launch = (state_q == IDLE) && (|pending_q);
        launch_mask = launch ? (N_BTN'(1) << sel) : '0;
        pending_d = (pending_q & ~launch_mask) | rise;
        cmd_addr = (sel == IDX_W'(N_BTN - 1)) ? ADDR_W'(ADDR_STARTPOS) : ADDR_W'(ADDR_ALGO);
        cmd_data = (sel == IDX_W'(N_BTN - 1)) ? pos_q : DATA_W'(int'(sel) + 1);
    end
    // request bookkeeping: pending mask, sticky overrun and start-position capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
            pos_q <= '0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_q | (|(rise & pending_q & ~launch_mask));
            if (rise[N_BTN-1]) pos_q <= byte_pos;
        end
    end
    // write FSM: launch from IDLE, hold the request in WRITE until acknowledged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (launch) begin
                    state_q <= WRITE;
                    mem_we_q <= 1'b1;
                    mem_addr_q <= cmd_addr;
                    mem_data_q <= cmd_data;
                end
            end else if (mem_ack) begin
                state_q <= IDLE;
                mem_we_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end
    assign mem_we = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy = (state_q == WRITE);
    assign done = done_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_mem_cmd_writer.sv
// tb_mem_cmd_writer: directed self-checking bench for mem_cmd_writer
module tb_mem_cmd_writer;
`ifdef BTN_DEBOUNCE_EN
    localparam int HOLD = 24;
`else
    localparam int HOLD = 4;
`endif
    logic clk = 1'b0;
    logic rst;
    logic [2:0] btn;
    logic [7:0] byte_pos;
    logic mem_ack;
    logic mem_we;
    logic [15:0] mem_addr;
    logic [7:0] mem_data;
    logic busy, done, overrun;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_n = 0;
    int we_cyc = 0;
    int done_n = 0;
    logic [15:0] log_addr [32];
    logic [7:0] log_data [32];
    int log_cyc [32];
    int b0, d0, w0;
    mem_cmd_writer dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .byte_pos(byte_pos),
        .mem_ack(mem_ack),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        cyc++;
        if (mem_we && mem_ack && wr_n < 32) begin
            log_addr[wr_n] = mem_addr;
            log_data[wr_n] = mem_data;
            log_cyc[wr_n] = cyc;
            wr_n++;
        end
        if (mem_we) we_cyc++;
        if (done) done_n++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_we(input string tag);
        int n = 0;
        while (!mem_we && n < 100) begin
            tick(1);
            n++;
        end
        check(tag, 32'(mem_we), 1);
    endtask
    initial begin
        rst = 1'b1;
        btn = '0;
        byte_pos = '0;
        mem_ack = 1'b0;
        tick(2);
        check("rst_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_data), 0);
        rst = 1'b0;
        tick(2);
        b0 = wr_n; d0 = done_n; w0 = we_cyc;
        btn = 3'b001;
`ifndef BTN_DEBOUNCE_EN
        tick(3);
        check("t1_lat_lo", 32'(mem_we), 0);
        tick(1);
        check("t1_lat_hi", 32'(mem_we), 1);
`endif
        wait_we("t1_we");
        check("t1_busy", 32'(busy), 1);
        tick(2);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        check("t1_done_hi", 32'(done), 1);
        check("t1_we_lo", 32'(mem_we), 0);
        tick(1);
        check("t1_done_lo", 32'(done), 0);
        tick(4);
        btn = '0;
        tick(6);
        check("t1_nwr", 32'(wr_n - b0), 1);
        check("t1_addr", 32'(log_addr[b0]), 32'h0000);
        check("t1_data", 32'(log_data[b0]), 32'h01);
        check("t1_we_cyc", 32'(we_cyc - w0), 3);
        check("t1_done_n", 32'(done_n - d0), 1);
        check("t1_ovr", 32'(overrun), 0);
        b0 = wr_n;
        byte_pos = 8'h2A;
        btn = 3'b100;
        wait_we("t2_we");
        byte_pos = 8'h55;
        tick(2);
        check("t2_addr_hold", 32'(mem_addr), 32'h0001);
        check("t2_data_hold", 32'(mem_data), 32'h2A);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        btn = '0;
        tick(6);
        check("t2_nwr", 32'(wr_n - b0), 1);
        check("t2_addr", 32'(log_addr[b0]), 32'h0001);
        check("t2_data", 32'(log_data[b0]), 32'h2A);
        b0 = wr_n;
        byte_pos = 8'h33;
        mem_ack = 1'b1;
        btn = 3'b111;
        tick(40);
        mem_ack = 1'b0;
        btn = '0;
        tick(4);
        check("t3_nwr", 32'(wr_n - b0), 3);
        check("t3_addr0", 32'(log_addr[b0]), 0);
        check("t3_data0", 32'(log_data[b0]), 32'h01);
        check("t3_addr1", 32'(log_addr[b0+1]), 0);
        check("t3_data1", 32'(log_data[b0+1]), 32'h02);
        check("t3_addr2", 32'(log_addr[b0+2]), 1);
        check("t3_data2", 32'(log_data[b0+2]), 32'h33);
        check("t3_gap01", 32'(log_cyc[b0+1] - log_cyc[b0]), 2);
        check("t3_gap12", 32'(log_cyc[b0+2] - log_cyc[b0+1]), 2);
        check("t3_ovr", 32'(overrun), 0);
        b0 = wr_n;
        btn = 3'b001;
        wait_we("t4_we");
        btn = 3'b011;
        tick(HOLD);
        btn = 3'b001;
        tick(HOLD);
        check("t4_ovr_first", 32'(overrun), 0);
        btn = 3'b011;
        tick(HOLD);
        btn = 3'b001;
        tick(HOLD);
        check("t4_ovr_set", 32'(overrun), 1);
        check("t4_stall", 32'(wr_n - b0), 0);
        btn = '0;
        mem_ack = 1'b1;
        tick(10);
        mem_ack = 1'b0;
        check("t4_nwr", 32'(wr_n - b0), 2);
        check("t4_data0", 32'(log_data[b0]), 32'h01);
        check("t4_addr1", 32'(log_addr[b0+1]), 0);
        check("t4_data1", 32'(log_data[b0+1]), 32'h02);
        tick(HOLD + 10);
        check("t4_ovr_sticky", 32'(overrun), 1);
        b0 = wr_n;
        btn = 3'b001;
        wait_we("t5_we");
        btn = 3'b111;
        tick(HOLD + 4);
        check("t5_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t5_we_async", 32'(mem_we), 0);
        check("t5_busy_async", 32'(busy), 0);
        check("t5_ovr_clr", 32'(overrun), 0);
        btn = '0;
        tick(2);
        rst = 1'b0;
        tick(30);
        check("t5_no_wr", 32'(wr_n - b0), 0);
        check("t5_we_idle", 32'(mem_we), 0);
        btn = 3'b010;
        mem_ack = 1'b1;
        tick(40);
        mem_ack = 1'b0;
        btn = '0;
        tick(4);
        check("t5_nwr", 32'(wr_n - b0), 1);
        check("t5_data", 32'(log_data[b0]), 32'h02);
`ifdef BTN_DEBOUNCE_EN
        b0 = wr_n;
        btn = 3'b001;
        tick(5);
        btn = '0;
        tick(40);
        check("t6_glitch", 32'(wr_n - b0), 0);
        btn = 3'b001;
        mem_ack = 1'b1;
        tick(20);
        btn = '0;
        tick(30);
        mem_ack = 1'b0;
        check("t6_nwr", 32'(wr_n - b0), 1);
        check("t6_data", 32'(log_data[b0]), 32'h01);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
